// File: rtl/peripheral_responder.sv
// I/O endpoint for the core's to/from_peripheral port pair.
// Buffers written words in a FIFO; answers each accepted command after RESP_DELAY.
module peripheral_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int RESP_DELAY      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int OCC_W = FIFO_DEPTH_BITS + 1;
  localparam int CNT_W = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_STAT = 2'b11;

  localparam logic [1:0] RC_OK   = 2'b01;
  localparam logic [1:0] RC_ERR  = 2'b10;
  localparam logic [1:0] RC_STAT = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [FIFO_DEPTH_BITS-1:0] wptr_q, wptr_d;
  logic [FIFO_DEPTH_BITS-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [7:0]                 drop_q, drop_d;
  logic [1:0]                 rcode_q, rcode_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [1:0]                 ocode_q, ocode_d;
  logic [DATA_WIDTH-1:0]      odata_q, odata_d;
  logic                       ovalid_q, ovalid_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cmd;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic [DATA_WIDTH-1:0] status;

  assign cmd   = to_peripheral_valid && (to_peripheral != 2'b00);
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  always_comb begin
    status        = '0;
    status[7:0]   = 8'(occ_q);
    status[15:8]  = drop_q;
    status[16]    = full;
    status[17]    = empty;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    rcode_d  = rcode_q;
    rdata_d  = rdata_q;
    ocode_d  = ocode_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RESP_DELAY - 1);
          rcode_d = RC_ERR;
          rdata_d = '0;
          unique case (to_peripheral)
            OP_WR: begin
              if (!full) begin
                push    = 1'b1;
                wptr_d  = wptr_q + 1'b1;
                occ_d   = occ_q + 1'b1;
                rcode_d = RC_OK;
                rdata_d = DATA_WIDTH'(occ_q + 1'b1);
              end
            end
            OP_RD: begin
              if (!empty) begin
                rptr_d  = rptr_q + 1'b1;
                occ_d   = occ_q - 1'b1;
                rcode_d = RC_OK;
                rdata_d = mem[rptr_q];
              end
            end
            OP_STAT: begin
              rcode_d = RC_STAT;
              rdata_d = status;
              drop_d  = '0;
            end
            default: ;
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          ovalid_d = 1'b1;
          ocode_d  = rcode_q;
          odata_d  = rdata_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        ovalid_d = 1'b0;
        ocode_d  = '0;
        odata_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    // Busy-window commands are discarded but counted (saturating)
    if (state_q != IDLE && cmd && drop_q != 8'hff)
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      drop_q   <= '0;
      rcode_q  <= '0;
      rdata_q  <= '0;
      ocode_q  <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
      drop_q   <= drop_d;
      rcode_q  <= rcode_d;
      rdata_q  <= rdata_d;
      ocode_q  <= ocode_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr_q] <= to_peripheral_data;
  end

  assign from_peripheral       = ocode_q;
  assign from_peripheral_data  = odata_q;
  assign from_peripheral_valid = ovalid_q;

endmodule

// File: tb/tb_peripheral_responder.sv
// Bench for peripheral_responder: directed plan plus random traffic
// against a queue-based busy-window reference model.
module tb_peripheral_responder;

  localparam int DW = 32;
  localparam int D  = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    op    = 2'b00;
  logic [DW-1:0] din   = '0;
  logic          vld   = 1'b0;
  logic [1:0]    rcode;
  logic [DW-1:0] rdata;
  logic          rvld;

  peripheral_responder #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH_BITS(3),
    .RESP_DELAY(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .to_peripheral(op),
    .to_peripheral_data(din),
    .to_peripheral_valid(vld),
    .from_peripheral(rcode),
    .from_peripheral_data(rdata),
    .from_peripheral_valid(rvld)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total    = 0;

  logic [DW-1:0] q[$];
  int            drops    = 0;
  int            e        = 0;
  int            next_acc = 0;
  int            resp_at  = -1;
  logic [1:0]    exp_code = '0;
  logic [DW-1:0] exp_data = '0;
  logic [1:0]    last_code;
  logic [DW-1:0] last_data;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] obs();
    return {29'b0, rvld, rcode, rdata};
  endfunction

  function automatic logic [63:0] expect_out();
    if (e == resp_at) return {29'b0, 1'b1, exp_code, exp_data};
    return 64'b0;
  endfunction

  task automatic model_edge(input logic [1:0] o, input logic [DW-1:0] d,
                            input logic v);
    if (!v || o == 2'b00) return;
    if (e < next_acc) begin
      if (drops < 255) drops++;
      return;
    end
    next_acc = e + D + 2;
    resp_at  = e + D;
    exp_code = 2'b10;
    exp_data = '0;
    case (o)
      2'b01: if (q.size() < 8) begin
        q.push_back(d);
        exp_code = 2'b01;
        exp_data = DW'(q.size());
      end
      2'b10: if (q.size() > 0) begin
        exp_code = 2'b01;
        exp_data = q.pop_front();
      end
      default: begin
        exp_code = 2'b11;
        exp_data = DW'(q.size()) | (DW'(drops) << 8)
                 | (DW'(q.size() == 8) << 16) | (DW'(q.size() == 0) << 17);
        drops = 0;
      end
    endcase
  endtask

  task automatic cycle(input logic [1:0] o, input logic [DW-1:0] d,
                       input logic v);
    op  = o;
    din = d;
    vld = v;
    @(posedge clock);
    e++;
    model_edge(o, d, v);
    #1;
    check("resp", obs(), expect_out());
    if (rvld) begin
      last_code = rcode;
      last_data = rdata;
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [DW-1:0] d);
    last_code = 'x;
    last_data = 'x;
    cycle(o, d, 1'b1);
    repeat (D + 1) cycle(2'b00, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    vld   = 1'b0;
    #1;
    check("rst_async", obs(), 64'b0);
    q.delete();
    drops    = 0;
    resp_at  = -1;
    next_acc = 0;
    @(posedge clock);
    e++;
    #1;
    check("rst_hold", obs(), 64'b0);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", obs(), 64'b0);
    reset = 1'b0;

    send(2'b01, 32'hAAAAA000);
    check("wr_first", {last_code, last_data}, {2'b01, 32'h1});

    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      send(2'b01, 32'hAAAAA000 + DW'(i));
      check("fill", {last_code, last_data}, {2'b01, DW'(i + 1)});
    end
    send(2'b01, 32'h12345678);
    check("wr_full", {last_code, last_data}, {2'b10, 32'h0});
    send(2'b11, '0);
    check("stat_full", {last_code, last_data}, {2'b11, 32'h00010008});

    for (int i = 0; i < 8; i++) begin
      send(2'b10, '0);
      check("drain", {last_code, last_data}, {2'b01, 32'hAAAAA000 + DW'(i)});
    end
    send(2'b10, '0);
    check("rd_empty", {last_code, last_data}, {2'b10, 32'h0});
    send(2'b11, '0);
    check("stat_empty", {last_code, last_data}, {2'b11, 32'h00020000});

    repeat (6) cycle(2'b01, 32'hBEEF0000, 1'b1);
    repeat (3) cycle(2'b00, '0, 1'b0);
    send(2'b11, '0);
    check("stat_drops", {last_code, last_data}, {2'b11, 32'h00000402});
    send(2'b11, '0);
    check("stat_clr", {last_code, last_data}, {2'b11, 32'h00000002});

    repeat (4) cycle(2'b00, 32'hFFFFFFFF, 1'b1);
    send(2'b11, '0);
    check("stat_nop", {last_code, last_data}, {2'b11, 32'h00000002});

    cycle(2'b01, 32'h5555AAAA, 1'b1);
    pulse_reset();
    repeat (3) cycle(2'b00, '0, 1'b0);
    send(2'b11, '0);
    check("stat_rst", {last_code, last_data}, {2'b11, 32'h00020000});

    cycle(2'b01, 32'h0000CAFE, 1'b1);
    cycle(2'b00, '0, 1'b0);
    pulse_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cycle(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
